// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one 1-bit adder/subtractor cell stepped LSB-first
// over WIDTH cycles, with a start/busy/done handshake and carry/overflow flags.

module serial_addsub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic op_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  logic b_eff;

  // Subtraction inverts B here; the +1 comes from the carry seeded with op.
  assign b_eff  = b_i ^ op_i;
  assign sum_o  = a_i ^ b_eff ^ cin_i;
  assign cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q, result_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_q, carry_q;
  logic               busy_q, done_q, cout_q, ovf_q;
  logic               sum_d, carry_d;

  serial_addsub_cell u_cell (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .op_i  (op_q),
    .cin_i (carry_q),
    .sum_o (sum_d),
    .cout_o(carry_d)
  );

  // NOTE: all state uses non-blocking assignments in one clocked block, so every
  // register sees pre-edge values and the async reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= op;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          result_q <= {sum_d, result_q[WIDTH-1:1]};
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // Overflow is the carry into the MSB xor the carry out of it.
            cout_q  <= carry_d;
            ovf_q   <= carry_q ^ carry_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl (WIDTH=8): the driver pushes expected
// results and done cycles, and a negedge monitor pops and compares on each done.

module tb_serial_addsub_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         op = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0, n_errors = 0;
  int   n_issued = 0, n_done = 0;
  logic prev_done = 1'b0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .op    (op),
    .busy  (busy),
    .done  (done),
    .result(result),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a +/- b as a 9-bit sum; overflow when the effective operands share
  // a sign bit that the result does not.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic o);
    logic [W-1:0] yy;
    logic [W:0]   s;
    logic         v;
    yy = o ? ~y : y;
    s  = {1'b0, x} + {1'b0, yy} + (W+1)'(o);
    v  = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
    return {v, s};
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      check("done_single_cycle", prev_done, 1'b0);
      check("busy_during_done", busy, 1'b1);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.r);
        check("cout", cout, e.c);
        check("ovf", ovf, e.v);
        check("done_latency", cyc, e.cyc);
      end
    end
    prev_done = done;
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iop,
                       input logic [W-1:0] er, input logic ec, input logic ev);
    int   budget;
    exp_t e;
    budget = 0;
    @(negedge clk);
    while (busy && budget < 40) begin
      budget++;
      @(negedge clk);
    end
    if (busy) check("idle_timeout", busy, 1'b0);
    a = ia; b = ib; op = iop; start = 1'b1;
    e.r = er; e.c = ec; e.v = ev; e.cyc = cyc + 1 + W;
    sb.push_back(e);
    n_issued++;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 1'($urandom);
    check("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    #1;
    while (sb.size() != 0 && budget < 50) begin
      budget++;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iop,
                        input logic [W-1:0] er, input logic ec, input logic ev);
    issue(ia, ib, iop, er, ec, ev);
    wait_drain();
  endtask

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] ra, rb;
    logic         rop;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 0);
    check("reset_cout", cout, 1'b0);
    check("reset_ovf", ovf, 1'b0);

    // T1..T3 directed vectors
    run_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    @(negedge clk);
    check("idle_busy_after_done", busy, 1'b0);
    check("result_held", result, 8'hFE);

    // T4 start while busy is ignored
    issue(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h11; b = 8'h22; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);
    check("t4_done_count", n_done, n_issued);
    check("t4_idle", busy, 1'b0);

    // T5 async reset at cnt=4
    issue(8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("t5_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    check("t5_rst_result", result, 0);
    check("t5_rst_cout", cout, 1'b0);
    check("t5_rst_ovf", ovf, 1'b0);
    void'(sb.pop_back());
    n_issued--;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_no_done", n_done, n_issued);
    run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);

    // T6 random vs reference model
    for (int i = 0; i < 1000; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 1'($urandom);
      m   = ref_model(ra, rb, rop);
      run_op(ra, rb, rop, m[W-1:0], m[W], m[W+1]);
    end

    repeat (12) @(negedge clk);
    check("final_done_count", n_done, n_issued);
    check("final_scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
